// File: rtl/column_slice_renderer.sv
// Column-sweep renderer: asks an external calculator for each column's wall height, then plots the column.
// Optional macro DEPTH_SHADE_EN: short wall slices (h < 32) are drawn in COL_WALL_DIM.
module column_slice_renderer #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter int         TIMEOUT      = 255,
  parameter logic [2:0] COL_CEIL     = 3'b001,
  parameter logic [2:0] COL_WALL     = 3'b110,
  parameter logic [2:0] COL_FLOOR    = 3'b010,
  parameter logic [2:0] COL_WALL_DIM = 3'b100
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_frame,
  output logic [7:0] column_count,
  output logic       begin_calc,
  input  logic [6:0] slice_size,
  input  logic       end_calc,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAW, NEXT, DONE} state_t;

  localparam logic [7:0] COL_LAST  = 8'(SCREEN_W - 1);
  localparam logic [6:0] ROW_LAST  = 7'(SCREEN_H - 1);
  localparam logic [6:0] H_MAX     = 7'(SCREEN_H);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] col;
  logic [6:0] row;
  logic [6:0] h;
  logic [6:0] top;
  logic [6:0] bottom;
  logic [7:0] wait_cnt;
  logic [6:0] h_new;
  logic [6:0] top_new;
  logic       wait_over;
  logic [2:0] wall_colour;
  logic [2:0] pixel_colour;

  // A timed-out request leaves end_calc low, so the latched height falls to zero.
  always_comb begin
    h_new = '0;
    if (end_calc)
      h_new = (slice_size > H_MAX) ? H_MAX : slice_size;
  end

  assign top_new   = (H_MAX - h_new) >> 1;
  assign wait_over = end_calc || (wait_cnt == WAIT_LAST);

`ifdef DEPTH_SHADE_EN
  assign wall_colour = (h < 7'd32) ? COL_WALL_DIM : COL_WALL;
`else
  logic [2:0] unused_wall_dim;
  assign unused_wall_dim = COL_WALL_DIM;
  assign wall_colour     = COL_WALL;
`endif

  always_comb begin
    pixel_colour = COL_FLOOR;
    if (row < top)
      pixel_colour = COL_CEIL;
    else if (row < bottom)
      pixel_colour = wall_colour;
  end

  always_ff @(posedge clock) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    column_count = '0;
    begin_calc   = 1'b0;
    x            = '0;
    y            = '0;
    colour       = '0;
    plot         = 1'b0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_frame)
          state_next = REQ;
      end
      REQ: begin
        begin_calc = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_over)
          state_next = DRAW;
      end
      DRAW: begin
        plot   = 1'b1;
        x      = col;
        y      = row;
        colour = pixel_colour;
        if (row == ROW_LAST)
          state_next = NEXT;
      end
      NEXT: begin
        state_next = (col == COL_LAST) ? DONE : REQ;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (busy)
      column_count = col;
    // Outputs are silenced for the whole time reset is held, not just after the edge.
    if (!resetn) begin
      column_count = '0;
      begin_calc   = 1'b0;
      x            = '0;
      y            = '0;
      colour       = '0;
      plot         = 1'b0;
      busy         = 1'b0;
      frame_done   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      col      <= '0;
      row      <= '0;
      h        <= '0;
      top      <= '0;
      bottom   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start_frame) col <= '0;
        REQ:  wait_cnt <= '0;
        WAIT: begin
          if (wait_over) begin
            h      <= h_new;
            top    <= top_new;
            bottom <= top_new + h_new;
            row    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DRAW: if (row != ROW_LAST) row <= row + 7'd1;
        NEXT: if (col != COL_LAST) col <= col + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_column_slice_renderer.sv
// Scoreboard bench for column_slice_renderer: a calculator model feeds random slice heights,
// expected pixels are queued per column and a separate monitor checks every plotted pixel.
module tb_column_slice_renderer;

  localparam int H   = 120;
  localparam int W   = 160;
  localparam int TMO = 255;
  localparam logic [2:0] C_CEIL  = 3'b001;
  localparam logic [2:0] C_WALL  = 3'b110;
  localparam logic [2:0] C_FLOOR = 3'b010;
  localparam logic [2:0] C_DIM   = 3'b100;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start_frame = 1'b0;
  logic       end_calc = 1'b0;
  logic [6:0] slice_size = '0;
  logic [7:0] column_count;
  logic       begin_calc;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t pix_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   begin_count = 0;
  int   plot_count = 0;
  int   done_count = 0;
  int   exp_col = 0;
  bit   pending = 1'b0;
  int   pend_cnt = 0;
  logic [6:0] pend_val = '0;

  column_slice_renderer dut (
    .clock        (clock),
    .resetn       (resetn),
    .start_frame  (start_frame),
    .column_count (column_count),
    .begin_calc   (begin_calc),
    .slice_size   (slice_size),
    .end_calc     (end_calc),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference picture of one column: vertically centred wall, ceiling above, floor below.
  function automatic void pushColumn(input int col, input int s, input bit answered);
    int h, top;
    logic [2:0] wall;
    pix_t p;
    h   = answered ? ((s > H) ? H : s) : 0;
    top = (H - h) / 2;
`ifdef DEPTH_SHADE_EN
    wall = (h < 32) ? C_DIM : C_WALL;
`else
    wall = C_WALL;
`endif
    for (int r = 0; r < H; r++) begin
      p.px = 8'(col);
      p.py = 7'(r);
      if (r < top)          p.pc = C_CEIL;
      else if (r < top + h) p.pc = wall;
      else                  p.pc = C_FLOOR;
      pix_q.push_back(p);
    end
  endfunction

  // Calculator model: answers a few cycles after begin_calc, sometimes never,
  // and occasionally raises a stray end_calc while pixels are being drawn.
  always @(negedge clock) begin
    int s, d, pick;
    end_calc = 1'b0;
    if (!resetn) begin
      pending = 1'b0;
      exp_col = 0;
    end else begin
      if (frame_done) exp_col = 0;
      if (pending) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          end_calc   = 1'b1;
          slice_size = pend_val;
          pending    = 1'b0;
        end
      end else if (plot && $urandom_range(0, 199) == 0) begin
        end_calc   = 1'b1;
        slice_size = 7'($urandom_range(0, 127));
      end
      if (begin_calc) begin
        checkOutput("column_count", column_count, exp_col);
        pick = $urandom_range(0, 9);
        case (pick)
          0: s = 0;
          1: s = 127;
          2: s = 40;
          3: s = 20;
          4: s = 120;
          default: s = $urandom_range(0, 127);
        endcase
        d = ($urandom_range(0, 1) == 0) ? 3 : $urandom_range(1, 6);
        if ($urandom_range(0, 49) == 0) begin
          pushColumn(exp_col, 0, 1'b0);
          lat_q.push_back(cyc + TMO + 1);
        end else begin
          pending  = 1'b1;
          pend_cnt = d;
          pend_val = 7'(s);
          pushColumn(exp_col, s, 1'b1);
          lat_q.push_back(cyc + d + 1);
        end
        exp_col++;
      end
    end
  end

  // Monitor: pops one expected pixel per plot cycle, independent of the stimulus.
  always @(negedge clock) begin
    pix_t e;
    int   exp_cyc;
    if (begin_calc) begin_count++;
    if (frame_done) done_count++;
    if (plot) begin
      plot_count++;
      checkOutput("busy_while_plot", busy, 1);
      if (pix_q.size() == 0) begin
        checkOutput("pixel_unexpected", {x, y, colour}, 18'h3ffff);
      end else begin
        e = pix_q.pop_front();
        checkOutput("pixel", {x, y, colour}, e);
      end
      if (y == 7'd0) begin
        if (lat_q.size() == 0) begin
          checkOutput("first_plot_unexpected", cyc, 0);
        end else begin
          exp_cyc = lat_q.pop_front();
          checkOutput("first_plot_cycle", cyc, exp_cyc);
        end
      end
    end
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_column_count"}, column_count, 0);
    checkOutput({tag, "_begin_calc"}, begin_calc, 0);
    checkOutput({tag, "_x"}, x, 0);
    checkOutput({tag, "_y"}, y, 0);
    checkOutput({tag, "_colour"}, colour, 0);
    checkOutput({tag, "_plot"}, plot, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1 start_frame = 1'b1;
    @(posedge clock);
    #1 start_frame = 1'b0;
  endtask

  task automatic waitBegins(input int target, input int budget);
    int n;
    n = 0;
    while (begin_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (begin_count < target) checkOutput("begin_wait_timeout", begin_count, target);
  endtask

  task automatic runFullFrame(input string tag);
    int b0, p0, d0, n;
    b0 = begin_count;
    p0 = plot_count;
    d0 = done_count;
    applyStimulus();
    waitBegins(b0 + 80, 40000);
    applyStimulus();
    n = 0;
    while (done_count == d0 && n < 70000) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "_frame_done_pulses"}, done_count - d0, 1);
    checkOutput({tag, "_begin_pulses"}, begin_count - b0, W);
    checkOutput({tag, "_plot_cycles"}, plot_count - p0, W * H);
    checkOutput({tag, "_pixels_left"}, pix_q.size(), 0);
    @(negedge clock);
    checkIdle({tag, "_idle"});
  endtask

  initial begin
    int b0, d0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkIdle("in_reset");
    @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    checkIdle("after_reset");

    runFullFrame("frame1");

    // Abort a frame partway through column 50.
    b0 = begin_count;
    d0 = done_count;
    applyStimulus();
    waitBegins(b0 + 51, 40000);
    repeat ($urandom_range(2, 40)) @(posedge clock);
    #1 resetn = 1'b0;
    #2 checkIdle("mid_reset_held");
    @(negedge clock);
    checkIdle("mid_reset_edge");
    @(posedge clock);
    #1 pix_q.delete();
    lat_q.delete();
    resetn = 1'b1;
    repeat (300) @(negedge clock);
    checkOutput("abort_no_frame_done", done_count - d0, 0);
    checkIdle("after_abort");

    runFullFrame("frame3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #950000;
    $display("[TB] FAIL watchdog actual=%0d expected=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
